// File: rtl/sync_fifo_pkg.sv
// Shared definitions for the synchronous FIFO.
//   FWFT_OFF / FWFT_ON : read-mode selectors for sync_fifo_flex.FWFT
//   ptr_w(depth)       : read/write pointer width
//   cnt_w(depth)       : occupancy counter width (holds 0..depth)
//   is_pow2(v)         : used to validate DEPTH at elaboration
package sync_fifo_pkg;

  localparam bit FWFT_OFF = 1'b0;
  localparam bit FWFT_ON  = 1'b1;

  function automatic int unsigned ptr_w(input int unsigned depth);
    return (depth > 1) ? $clog2(depth) : 1;
  endfunction

  function automatic int unsigned cnt_w(input int unsigned depth);
    return $clog2(depth) + 1;
  endfunction

  function automatic bit is_pow2(input int unsigned v);
    return (v != 0) && ((v & (v - 1)) == 0);
  endfunction

endpackage

// File: rtl/fifo_dpram.sv
// Storage array for sync_fifo_flex: one synchronous write port and one
// combinational read port. Contents are never reset.
//   clk      : clock
//   we_i     : write enable
//   waddr_i  : write address
//   wdata_i  : write data
//   raddr_i  : read address
//   rdata_o  : read data (combinational from raddr_i)
module fifo_dpram #(
  parameter int unsigned DATA_W = 8,
  parameter int unsigned DEPTH  = 16,
  parameter int unsigned AW     = 4
) (
  input  logic              clk,
  input  logic              we_i,
  input  logic [AW-1:0]     waddr_i,
  input  logic [DATA_W-1:0] wdata_i,
  input  logic [AW-1:0]     raddr_i,
  output logic [DATA_W-1:0] rdata_o
);

  logic [DATA_W-1:0] mem_q [DEPTH];

  always_ff @(posedge clk) begin
    if (we_i) begin
      mem_q[waddr_i] <= wdata_i;
    end
  end

  assign rdata_o = mem_q[raddr_i];

endmodule

// File: rtl/sync_fifo_flex.sv
// Single-clock FIFO with registered occupancy/threshold flags, overflow and
// underflow pulses, and selectable registered-read or first-word-fall-through
// output.
//   clk          : clock, all state on rising edge
//   rst_a        : synchronous active-high reset (memory not cleared)
//   wr_en        : write request
//   data_in      : write data
//   rd_en        : read / pop request
//   data_out     : read data (FWFT=0: loaded on accepted read;
//                  FWFT=1: head entry whenever not empty)
//   full/empty   : occupancy flags
//   almost_full  : count >= AF_LEVEL
//   almost_empty : count <= AE_LEVEL
//   count        : occupancy 0..DEPTH
//   overflow     : one-cycle pulse for a write dropped while full
//   underflow    : one-cycle pulse for a read rejected while empty
module sync_fifo_flex
  import sync_fifo_pkg::*;
#(
  parameter int unsigned DATA_W   = 8,
  parameter int unsigned DEPTH    = 16,
  parameter int unsigned AF_LEVEL = DEPTH - 2,
  parameter int unsigned AE_LEVEL = 2,
  parameter bit          FWFT     = FWFT_OFF
) (
  input  logic                      clk,
  input  logic                      rst_a,
  input  logic                      wr_en,
  input  logic [DATA_W-1:0]         data_in,
  input  logic                      rd_en,
  output logic [DATA_W-1:0]         data_out,
  output logic                      full,
  output logic                      empty,
  output logic                      almost_full,
  output logic                      almost_empty,
  output logic [cnt_w(DEPTH)-1:0]   count,
  output logic                      overflow,
  output logic                      underflow
);

  localparam int unsigned AW = ptr_w(DEPTH);
  localparam int unsigned CW = cnt_w(DEPTH);

  localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);
  localparam logic [CW-1:0] AF_C    = CW'(AF_LEVEL);
  localparam logic [CW-1:0] AE_C    = CW'(AE_LEVEL);

  if (!is_pow2(DEPTH) || DEPTH < 4) begin : g_bad_depth
    $error("sync_fifo_flex: DEPTH must be a power of two and at least 4");
  end
  if (!(AE_LEVEL < AF_LEVEL && AF_LEVEL <= DEPTH)) begin : g_bad_levels
    $error("sync_fifo_flex: need AE_LEVEL < AF_LEVEL <= DEPTH");
  end
  if (DATA_W < 1 || DATA_W > 64) begin : g_bad_width
    $error("sync_fifo_flex: DATA_W must be in 1..64");
  end

  logic [AW-1:0]     wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]     rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]     count_q, count_d;
  logic              full_q, full_d;
  logic              empty_q, empty_d;
  logic              af_q, af_d;
  logic              ae_q, ae_d;
  logic              ovf_q, ovf_d;
  logic              unf_q, unf_d;
  logic [DATA_W-1:0] dout_q, dout_d;

  logic              wr_acc;
  logic              rd_acc;
  logic              ram_we;
  logic [AW-1:0]     ram_raddr;
  logic [DATA_W-1:0] ram_rdata;

  // Pointer, count and flag next-state
  always_comb begin
    // A full FIFO still takes a write when a pop frees a slot the same cycle.
    wr_acc   = wr_en && (!full_q || rd_en);
    rd_acc   = rd_en && !empty_q;
    wr_ptr_d = wr_acc ? wr_ptr_q + AW'(1) : wr_ptr_q;
    rd_ptr_d = rd_acc ? rd_ptr_q + AW'(1) : rd_ptr_q;
    count_d  = count_q;
    case ({wr_acc, rd_acc})
      2'b10:   count_d = count_q + CW'(1);
      2'b01:   count_d = count_q - CW'(1);
      default: count_d = count_q;
    endcase
    full_d  = (count_d == DEPTH_C);
    empty_d = (count_d == '0);
    af_d    = (count_d >= AF_C);
    ae_d    = (count_d <= AE_C);
    ovf_d   = wr_en && !rd_en && full_q;
    unf_d   = rd_en && empty_q;
  end

  // In FWFT mode the RAM is addressed with the post-edge head pointer so the
  // output register already holds the new head once the edge has passed.
  assign ram_raddr = (FWFT == FWFT_ON) ? rd_ptr_d : rd_ptr_q;
  assign ram_we    = wr_acc && !rst_a;

  always_comb begin
    dout_d = dout_q;
    if (FWFT == FWFT_ON) begin
      if (count_d != '0) begin
        // The word being written this cycle becomes the head only when it
        // lands in the head slot; it is not in the RAM yet, so bypass it.
        dout_d = (wr_acc && (wr_ptr_q == rd_ptr_d)) ? data_in : ram_rdata;
      end
    end else if (rd_acc) begin
      dout_d = ram_rdata;
    end
  end

  fifo_dpram #(
    .DATA_W (DATA_W),
    .DEPTH  (DEPTH),
    .AW     (AW)
  ) u_ram (
    .clk     (clk),
    .we_i    (ram_we),
    .waddr_i (wr_ptr_q),
    .wdata_i (data_in),
    .raddr_i (ram_raddr),
    .rdata_o (ram_rdata)
  );

  always_ff @(posedge clk) begin
    if (rst_a) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      full_q   <= 1'b0;
      empty_q  <= 1'b1;
      af_q     <= 1'b0;
      ae_q     <= 1'b1;
      ovf_q    <= 1'b0;
      unf_q    <= 1'b0;
      dout_q   <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      full_q   <= full_d;
      empty_q  <= empty_d;
      af_q     <= af_d;
      ae_q     <= ae_d;
      ovf_q    <= ovf_d;
      unf_q    <= unf_d;
      dout_q   <= dout_d;
    end
  end

  assign data_out     = dout_q;
  assign full         = full_q;
  assign empty        = empty_q;
  assign almost_full  = af_q;
  assign almost_empty = ae_q;
  assign count        = count_q;
  assign overflow     = ovf_q;
  assign underflow    = unf_q;

endmodule

// File: tb/tb_sync_fifo_flex.sv
module tb_sync_fifo_flex;

  localparam int DW = 4;
  localparam int DP = 8;
  localparam int AF = 6;
  localparam int AE = 2;

  logic          clk = 1'b0;
  logic          rst_a = 1'b1;
  logic          wr_en = 1'b0;
  logic          rd_en = 1'b0;
  logic [DW-1:0] data_in = '0;

  logic [DW-1:0] dout0, dout1;
  logic          full0, empty0, af0, ae0, ovf0, unf0;
  logic          full1, empty1, af1, ae1, ovf1, unf1;
  logic [3:0]    cnt0, cnt1;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  sync_fifo_flex #(.DATA_W(DW), .DEPTH(DP), .AF_LEVEL(AF), .AE_LEVEL(AE), .FWFT(1'b0)) u_dut0 (
    .clk(clk), .rst_a(rst_a), .wr_en(wr_en), .data_in(data_in), .rd_en(rd_en),
    .data_out(dout0), .full(full0), .empty(empty0), .almost_full(af0), .almost_empty(ae0),
    .count(cnt0), .overflow(ovf0), .underflow(unf0)
  );

  sync_fifo_flex #(.DATA_W(DW), .DEPTH(DP), .AF_LEVEL(AF), .AE_LEVEL(AE), .FWFT(1'b1)) u_dut1 (
    .clk(clk), .rst_a(rst_a), .wr_en(wr_en), .data_in(data_in), .rd_en(rd_en),
    .data_out(dout1), .full(full1), .empty(empty1), .almost_full(af1), .almost_empty(ae1),
    .count(cnt1), .overflow(ovf1), .underflow(unf1)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step(input logic w, input logic r, input logic [DW-1:0] d);
    wr_en   = w;
    rd_en   = r;
    data_in = d;
    @(posedge clk);
    #1;
  endtask

  task automatic chk_flags(input string tag, input int n);
    chk({tag, ".cnt0"},   32'(cnt0),   32'(n));
    chk({tag, ".cnt1"},   32'(cnt1),   32'(n));
    chk({tag, ".full0"},  32'(full0),  32'(n == DP));
    chk({tag, ".empty0"}, 32'(empty0), 32'(n == 0));
    chk({tag, ".af0"},    32'(af0),    32'(n >= AF));
    chk({tag, ".ae0"},    32'(ae0),    32'(n <= AE));
    chk({tag, ".full1"},  32'(full1),  32'(n == DP));
    chk({tag, ".empty1"}, 32'(empty1), 32'(n == 0));
    chk({tag, ".af1"},    32'(af1),    32'(n >= AF));
    chk({tag, ".ae1"},    32'(ae1),    32'(n <= AE));
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [DW-1:0] q[$];
    logic [DW-1:0] exp_d0;
    logic          w, r;
    logic          exp_ovf, exp_unf;

    // reset
    step(1'b0, 1'b0, '0);
    step(1'b0, 1'b0, '0);
    chk_flags("rst", 0);
    chk("rst.ovf0",  32'(ovf0),  32'(0));
    chk("rst.unf0",  32'(unf0),  32'(0));
    chk("rst.dout0", 32'(dout0), 32'(0));
    chk("rst.dout1", 32'(dout1), 32'(0));
    rst_a = 1'b0;

    // fill 1..8, then an overflowing 9th write
    for (int i = 1; i <= 8; i++) begin
      step(1'b1, 1'b0, DW'(i));
      chk_flags($sformatf("fill%0d", i), i);
      chk($sformatf("fill%0d.dout1", i), 32'(dout1), 32'(1));
      chk($sformatf("fill%0d.dout0", i), 32'(dout0), 32'(0));
    end
    step(1'b1, 1'b0, 4'd9);
    chk("ovf.pulse0", 32'(ovf0), 32'(1));
    chk("ovf.pulse1", 32'(ovf1), 32'(1));
    chk_flags("ovf", 8);
    step(1'b0, 1'b0, '0);
    chk("ovf.clear0", 32'(ovf0), 32'(0));
    chk("ovf.clear1", 32'(ovf1), 32'(0));

    // drain 1..8, then an underflowing 9th read
    for (int i = 1; i <= 8; i++) begin
      step(1'b0, 1'b1, '0);
      chk($sformatf("drain%0d.dout0", i), 32'(dout0), 32'(i));
      chk_flags($sformatf("drain%0d", i), 8 - i);
      if (i < 8) chk($sformatf("drain%0d.dout1", i), 32'(dout1), 32'(i + 1));
    end
    step(1'b0, 1'b1, '0);
    chk("unf.pulse0", 32'(unf0),  32'(1));
    chk("unf.dout0",  32'(dout0), 32'(8));
    chk_flags("unf", 0);
    step(1'b0, 1'b0, '0);
    chk("unf.clear0", 32'(unf0),  32'(0));
    chk("unf.hold0",  32'(dout0), 32'(8));

    // full with simultaneous read and write
    for (int i = 1; i <= 8; i++) step(1'b1, 1'b0, DW'(i));
    chk_flags("refill", 8);
    step(1'b1, 1'b1, 4'd9);
    chk_flags("fullrw", 8);
    chk("fullrw.dout0", 32'(dout0), 32'(1));
    chk("fullrw.dout1", 32'(dout1), 32'(2));
    chk("fullrw.ovf0",  32'(ovf0),  32'(0));
    for (int i = 0; i < 8; i++) begin
      step(1'b0, 1'b1, '0);
      chk($sformatf("fullrw.rd%0d", i), 32'(dout0), (i < 7) ? 32'(i + 2) : 32'(9));
    end
    chk_flags("fullrw.end", 0);

    // empty with simultaneous read and write
    step(1'b1, 1'b1, 4'd5);
    chk("emptyrw.unf0",  32'(unf0),  32'(1));
    chk("emptyrw.unf1",  32'(unf1),  32'(1));
    chk_flags("emptyrw", 1);
    chk("emptyrw.dout1", 32'(dout1), 32'(5));
    chk("emptyrw.dout0", 32'(dout0), 32'(9));
    step(1'b0, 1'b1, '0);
    chk("emptyrw.rd0",   32'(dout0), 32'(5));
    chk_flags("emptyrw.end", 0);

    // reset in the middle of traffic, with a write in flight
    for (int i = 1; i <= 5; i++) step(1'b1, 1'b0, DW'(i));
    chk_flags("pre_rst", 5);
    rst_a = 1'b1;
    step(1'b1, 1'b0, 4'd7);
    rst_a = 1'b0;
    chk_flags("mid_rst", 0);
    chk("mid_rst.dout0", 32'(dout0), 32'(0));
    chk("mid_rst.dout1", 32'(dout1), 32'(0));
    step(1'b0, 1'b0, '0);
    chk_flags("post_rst", 0);
    for (int i = 0; i < 3; i++) begin
      step(1'b1, 1'b0, DW'(10 + i));
      chk($sformatf("post_rst.wr%0d.dout1", i), 32'(dout1), 32'(10));
    end
    chk_flags("post_rst.wr", 3);
    for (int i = 0; i < 3; i++) begin
      step(1'b0, 1'b1, '0);
      chk($sformatf("post_rst.rd%0d", i), 32'(dout0), 32'(10 + i));
    end
    chk_flags("post_rst.rd", 0);

    // interleaved traffic across the pointer wrap, queue model
    exp_d0 = 4'd12;
    for (int k = 0; k < 24; k++) begin
      w       = 1'b1;
      r       = (k % 4) != 0;
      exp_ovf = w && !r && (q.size() == DP);
      exp_unf = r && (q.size() == 0);
      if (r && q.size() > 0) exp_d0 = q.pop_front();
      if (w && (q.size() < DP)) q.push_back(DW'(k + 1));
      step(w, r, DW'(k + 1));
      chk($sformatf("mix%0d.dout0", k), 32'(dout0), 32'(exp_d0));
      chk($sformatf("mix%0d.ovf0", k),  32'(ovf0),  32'(exp_ovf));
      chk($sformatf("mix%0d.unf0", k),  32'(unf0),  32'(exp_unf));
      chk_flags($sformatf("mix%0d", k), q.size());
      if (q.size() > 0) chk($sformatf("mix%0d.dout1", k), 32'(dout1), 32'(q[0]));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
